// File: rtl/uart_pkg.sv
// Shared defaults, divisor type and default-divisor calculation for uart_baud_gen.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DIV_WIDTH_DEF  = 16;
    localparam int FRAC_WIDTH_DEF = 4;

    typedef struct packed {
        logic [31:0] div_int;
        logic [31:0] div_frac;
    } divisor_t;

    function automatic divisor_t calc_def_div(input longint clock_rate,
                                              input longint baud_rate,
                                              input longint oversample,
                                              input int     frac_width);
        divisor_t d;
        longint   den;
        longint   q;
        longint   r;
        longint   f;
        den = baud_rate * oversample;
        q   = clock_rate / den;
        r   = clock_rate - q * den;
        f   = ((r << frac_width) + den / 2) / den;
        // A remainder that rounds up to a whole clock belongs to the integer part.
        if (f >= (longint'(1) << frac_width)) begin
            q = q + 1;
            f = 0;
        end
        d.div_int  = 32'(q);
        d.div_frac = 32'(f);
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable UART baud generator: sample_tick per oversample period, bit_tick per bit.
// Define UART_BAUD_FRAC_EN to build the fractional divisor accumulator.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    localparam int IDX_W     = $clog2(OVERSAMPLE)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DIV_WIDTH-1:0]  div_int,
    input  logic [FRAC_WIDTH-1:0] div_frac,
    input  logic                  div_load,
    input  logic                  resync,
    output logic                  sample_tick,
    output logic                  bit_tick,
    output logic [IDX_W-1:0]      sample_idx
);

    localparam divisor_t DEF_DIV = calc_def_div(longint'(CLOCK_RATE), longint'(BAUD_RATE),
                                                longint'(OVERSAMPLE), FRAC_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DEF_INT =
        (DEF_DIV.div_int < 32'd2) ? DIV_WIDTH'(2) : DEF_DIV.div_int[DIV_WIDTH-1:0];
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] sh_int_q;
    logic [DIV_WIDTH-1:0] pend_int_q;
    logic                 pend_vld_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 tick_q;
    logic                 bit_q;
    logic [DIV_WIDTH-1:0] load_int;
    logic [DIV_WIDTH-1:0] nxt_int_d;
    logic [DIV_WIDTH-1:0] reload_d;
    logic                 expire;
    logic                 carry_d;

    // Clamp at capture so the shadow never holds a divisor that could produce adjacent ticks.
    assign load_int = (div_int < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_int;
    assign expire   = en && (cnt_q == '0);

`ifdef UART_BAUD_FRAC_EN
    localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = DEF_DIV.div_frac[FRAC_WIDTH-1:0];

    logic [FRAC_WIDTH-1:0] sh_frac_q;
    logic [FRAC_WIDTH-1:0] pend_frac_q;
    logic [FRAC_WIDTH-1:0] frac_acc_q;
    logic [FRAC_WIDTH-1:0] nxt_frac_d;
    logic [FRAC_WIDTH-1:0] frac_acc_d;

    always_comb begin
        nxt_frac_d = sh_frac_q;
        if (div_load)
            nxt_frac_d = div_frac;
        else if (pend_vld_q)
            nxt_frac_d = pend_frac_q;
        {carry_d, frac_acc_d} = {1'b0, frac_acc_q} + {1'b0, nxt_frac_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_frac_q   <= DEF_FRAC;
            pend_frac_q <= '0;
            frac_acc_q  <= '0;
        end else if (resync) begin
            sh_frac_q  <= nxt_frac_d;
            frac_acc_q <= '0;
        end else begin
            if (div_load)
                pend_frac_q <= div_frac;
            if (expire) begin
                sh_frac_q  <= nxt_frac_d;
                frac_acc_q <= frac_acc_d;
            end
        end
    end
`else
    logic unused_frac;
    assign carry_d     = 1'b0;
    assign unused_frac = ^div_frac;
`endif

    // A load in the same cycle as a reload or resync takes effect immediately (last load wins).
    always_comb begin
        nxt_int_d = sh_int_q;
        if (div_load)
            nxt_int_d = load_int;
        else if (pend_vld_q)
            nxt_int_d = pend_int_q;
        reload_d = nxt_int_d - DIV_WIDTH'(1) + DIV_WIDTH'(carry_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= DEF_INT - DIV_WIDTH'(1);
            sh_int_q   <= DEF_INT;
            pend_int_q <= '0;
            pend_vld_q <= 1'b0;
            idx_q      <= '0;
            tick_q     <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            bit_q  <= 1'b0;
            if (resync) begin
                cnt_q      <= nxt_int_d - DIV_WIDTH'(1);
                sh_int_q   <= nxt_int_d;
                pend_vld_q <= 1'b0;
                idx_q      <= '0;
            end else begin
                if (div_load) begin
                    pend_int_q <= load_int;
                    pend_vld_q <= 1'b1;
                end
                if (expire) begin
                    tick_q     <= 1'b1;
                    bit_q      <= (idx_q == IDX_LAST);
                    idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    cnt_q      <= reload_d;
                    sh_int_q   <= nxt_int_d;
                    pend_vld_q <= 1'b0;
                end else if (en) begin
                    cnt_q <= cnt_q - DIV_WIDTH'(1);
                end
            end
        end
    end

    assign sample_tick = tick_q;
    assign bit_tick    = bit_q;
    assign sample_idx  = idx_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus random stimulus vs. a
// tick-deadline reference model.
module tb_uart_baud_gen;

`ifdef UART_BAUD_FRAC_EN
    localparam int FRAC_EN = 1;
`else
    localparam int FRAC_EN = 0;
`endif
    // 100 MHz / (9600*16) = 651 rem 6400 -> 6400*16/153600 = 0.67 rounds to 1/16.
    localparam int DEF_INT  = 651;
    localparam int DEF_FRAC = FRAC_EN ? 1 : 0;
    localparam int OS       = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        resync;
    logic        sample_tick;
    logic        bit_tick;
    logic [3:0]  sample_idx;

    uart_baud_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .resync      (resync),
        .sample_tick (sample_tick),
        .bit_tick    (bit_tick),
        .sample_idx  (sample_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int e_cnt = 0;
    int t_rs  = 0;
    int tick_times[$];
    int bit_times[$];

    // Reference model: absolute edge of the next tick plus divisor bookkeeping.
    int m_due, m_idx, m_acc, m_sh_int, m_sh_frac, m_pd_int, m_pd_frac;
    bit m_pd_v;
    int exp_tick, exp_bit, exp_idx;

    task automatic check_eq(input string tag, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, req, e_cnt);
        end
    endtask

    function automatic int clamp2(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_sh_int  = DEF_INT;
        m_sh_frac = DEF_FRAC;
        m_pd_v    = 1'b0;
        m_idx     = 0;
        m_acc     = 0;
        m_due     = e_cnt + DEF_INT;
    endtask

    task automatic model_apply();
        if (m_pd_v) begin
            m_sh_int  = m_pd_int;
            m_sh_frac = m_pd_frac;
            m_pd_v    = 1'b0;
        end
    endtask

    task automatic model_edge();
        int carry;
        exp_tick = 0;
        exp_bit  = 0;
        if (div_load) begin
            m_pd_int  = clamp2(int'(div_int));
            m_pd_frac = FRAC_EN ? int'(div_frac) : 0;
            m_pd_v    = 1'b1;
        end
        if (resync) begin
            model_apply();
            m_due = e_cnt + m_sh_int;
            m_idx = 0;
            m_acc = 0;
        end else if (!en) begin
            m_due++;
        end else if (e_cnt == m_due) begin
            model_apply();
            exp_tick = 1;
            exp_bit  = (m_idx == OS - 1) ? 1 : 0;
            m_idx    = (m_idx + 1) % OS;
            carry    = ((m_acc + m_sh_frac) >= 16) ? 1 : 0;
            m_acc    = (m_acc + m_sh_frac) % 16;
            m_due    = e_cnt + m_sh_int + carry;
        end
        exp_idx = m_idx;
    endtask

    task automatic step();
        e_cnt++;
        model_edge();
        @(posedge clk);
        #1;
        check_eq("sample_tick", int'(sample_tick), exp_tick);
        check_eq("bit_tick", int'(bit_tick), exp_bit);
        check_eq("sample_idx", int'(sample_idx), exp_idx);
        if (sample_tick) tick_times.push_back(e_cnt);
        if (bit_tick) bit_times.push_back(e_cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_ticks(input int nt, input int max_cyc);
        int c;
        c = 0;
        while (tick_times.size() < nt && c < max_cyc) begin
            step();
            c++;
        end
        if (tick_times.size() < nt) check_eq("tick_timeout", tick_times.size(), nt);
    endtask

    task automatic load_resync(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        resync   = 1'b1;
        tick_times.delete();
        bit_times.delete();
        step();
        div_load = 1'b0;
        resync   = 1'b0;
        t_rs     = e_cnt;
    endtask

    initial begin
        int t_ref;
        int idx_exp;
        int c;
        rst_n = 1'b0; en = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0; resync = 1'b0;
        #23;
        check_eq("rst_tick", int'(sample_tick), 0);
        check_eq("rst_bit", int'(bit_tick), 0);
        check_eq("rst_idx", int'(sample_idx), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        model_reset();

        // Default divisor: first tick latency, 16-period span, bit on the 16th tick.
        run_ticks(17, 12000);
        check_eq("first_tick", tick_times[0], DEF_INT);
        check_eq("span16_default", tick_times[16] - tick_times[0], FRAC_EN ? 10417 : 10416);
        check_eq("bit_on_16th", bit_times[0], tick_times[15]);

        // Integer divisor 4.
        load_resync(4, 0);
        run_ticks(33, 300);
        check_eq("div4_first", tick_times[0] - t_rs, 4);
        check_eq("div4_period", tick_times[1] - tick_times[0], 4);
        check_eq("div4_bit_at_16", bit_times[0], tick_times[15]);
        check_eq("div4_bit_period", bit_times[1] - bit_times[0], 64);

        // Fractional divisor 4 + 8/16.
        load_resync(4, 8);
        run_ticks(17, 300);
        check_eq("frac_span16", tick_times[16] - tick_times[0], FRAC_EN ? 72 : 64);

        // Load of 6 two clocks into a 4-clock period.
        load_resync(4, 0);
        run_ticks(1, 10);
        t_ref = tick_times[0];
        tick_times.delete();
        step();
        div_int = 16'd6; div_frac = 4'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        run_ticks(3, 40);
        check_eq("load_cur_period", tick_times[0] - t_ref, 4);
        check_eq("load_new_period1", tick_times[1] - tick_times[0], 6);
        check_eq("load_new_period2", tick_times[2] - tick_times[1], 6);

        // Resync on the expiry edge.
        load_resync(4, 0);
        run(10);
        c = 0;
        while (e_cnt + 1 != m_due && c < 10) begin
            step();
            c++;
        end
        resync = 1'b1;
        step();
        resync = 1'b0;
        t_rs = e_cnt;
        check_eq("rs_no_tick", int'(sample_tick), 0);
        check_eq("rs_idx", int'(sample_idx), 0);
        tick_times.delete();
        run_ticks(1, 10);
        check_eq("rs_next_tick", tick_times[0] - t_rs, 4);

        // en low for 10 clocks mid-period.
        tick_times.delete();
        run_ticks(1, 10);
        t_ref   = tick_times[0];
        idx_exp = (m_idx + 1) % OS;
        run(2);
        en = 1'b0;
        run(10);
        en = 1'b1;
        tick_times.delete();
        run_ticks(1, 30);
        check_eq("en_hold_period", tick_times[0] - t_ref, 14);
        check_eq("en_hold_idx", int'(sample_idx), idx_exp);

        // Reset mid-period with a pending load that must be discarded.
        tick_times.delete();
        run_ticks(1, 10);
        div_int = 16'd7; div_load = 1'b1;
        step();
        div_load = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tick", int'(sample_tick), 0);
        check_eq("midrst_bit", int'(bit_tick), 0);
        check_eq("midrst_idx", int'(sample_idx), 0);
        #20;
        rst_n = 1'b1;
        t_ref = e_cnt;
        model_reset();
        tick_times.delete();
        bit_times.delete();
        run_ticks(2, 1500);
        check_eq("midrst_first_tick", tick_times[0] - t_ref, DEF_INT);
        check_eq("midrst_no_pending", tick_times[1] - tick_times[0], DEF_INT);

        // div_int=1 clamps to 2.
        load_resync(1, 0);
        run_ticks(3, 20);
        check_eq("clamp_first", tick_times[0] - t_rs, 2);
        check_eq("clamp_period", tick_times[1] - tick_times[0], 2);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            resync   = ($urandom_range(0, 199) == 0);
            div_load = ($urandom_range(0, 49) == 0);
            div_int  = 16'($urandom_range(0, 9));
            div_frac = 4'($urandom_range(0, 15));
            step();
        end
        en = 1'b1; resync = 1'b0; div_load = 1'b0;
        run(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
